// File: rtl/fb_ddram_arbiter.sv
// Arbitrates the DDR3 command port between a posted pixel-write FIFO (port A)
// and one generic read/write requester (port B); commands hold until DDRAM_BUSY drops.
module fb_ddram_arbiter #(
    parameter int FIFO_AW = 4,
    parameter int HWM     = 12
) (
    input  logic        CLK_VIDEO,
    input  logic        RESET_N,

    input  logic        A_WE,
    input  logic [28:0] A_ADDR,
    input  logic [63:0] A_DIN,
    input  logic [7:0]  A_BE,
    output logic        A_FULL,
    output logic        A_OVF,

    input  logic        B_REQ,
    input  logic        B_WE,
    input  logic [28:0] B_ADDR,
    input  logic [63:0] B_DIN,
    input  logic [7:0]  B_BE,
    output logic        B_ACK,
    output logic [63:0] B_DOUT,

    output logic        DDRAM_CLK,
    input  logic        DDRAM_BUSY,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    output logic        DDRAM_RD
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   C_DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   C_HWM     = (FIFO_AW+1)'(HWM);
    localparam logic [FIFO_AW:0]   C_CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] C_PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_RDWAIT = 2'd2;

    logic [100:0]       r_mem [0:DEPTH-1];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;

    logic [1:0]         r_state;
    logic               r_last_a;
    logic               r_cmd_b;
    logic               r_we;
    logic               r_rd;
    logic               r_b_ack;
    logic [28:0]        r_addr;
    logic [63:0]        r_din;
    logic [7:0]         r_be;
    logic [63:0]        r_b_dout;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_a_cand;
    logic               w_b_cand;
    logic               w_hwm;
    logic               w_grant_a;
    logic               w_grant_b;
    logic [100:0]       w_head;

    assign w_full   = (r_count == C_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_hwm    = (r_count >= C_HWM);
    assign w_a_cand = !w_empty;
    // B_ACK masks the cycle in which the requester is still dropping B_REQ
    assign w_b_cand = B_REQ && !r_b_ack;

    assign w_grant_a = (r_state == S_IDLE) && w_a_cand && (!w_b_cand || w_hwm || !r_last_a);
    assign w_grant_b = (r_state == S_IDLE) && w_b_cand && !w_grant_a;

    assign w_push = A_WE && !w_full;
    assign w_pop  = w_grant_a;
    assign w_head = r_mem[r_rptr];

    always_ff @(posedge CLK_VIDEO) begin
        if (w_push) begin
            r_mem[r_wptr] <= {A_ADDR, A_DIN, A_BE};
        end
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (A_WE && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            r_state  <= S_IDLE;
            r_last_a <= 1'b0;
            r_cmd_b  <= 1'b0;
            r_we     <= 1'b0;
            r_rd     <= 1'b0;
            r_b_ack  <= 1'b0;
            r_addr   <= '0;
            r_din    <= '0;
            r_be     <= '0;
            r_b_dout <= '0;
        end else begin
            r_b_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_a) begin
                        {r_addr, r_din, r_be} <= w_head;
                        r_we     <= 1'b1;
                        r_rd     <= 1'b0;
                        r_cmd_b  <= 1'b0;
                        r_last_a <= 1'b1;
                        r_state  <= S_ISSUE;
                    end else if (w_grant_b) begin
                        r_addr   <= B_ADDR;
                        r_din    <= B_DIN;
                        r_be     <= B_BE;
                        r_we     <= B_WE;
                        r_rd     <= !B_WE;
                        r_cmd_b  <= 1'b1;
                        r_last_a <= 1'b0;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        r_we <= 1'b0;
                        r_rd <= 1'b0;
                        if (r_rd) begin
                            r_state <= S_RDWAIT;
                        end else begin
                            r_b_ack <= r_cmd_b;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RDWAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        r_b_dout <= DDRAM_DOUT;
                        r_b_ack  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign A_FULL         = w_full;
    assign A_OVF          = r_ovf;
    assign B_ACK          = r_b_ack;
    assign B_DOUT         = r_b_dout;
    assign DDRAM_CLK      = CLK_VIDEO;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = r_addr;
    assign DDRAM_DIN      = r_din;
    assign DDRAM_BE       = r_be;
    assign DDRAM_WE       = r_we;
    assign DDRAM_RD       = r_rd;

endmodule

// File: tb/tb_fb_ddram_arbiter.sv
// Bench for fb_ddram_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_fb_ddram_arbiter;

    localparam int DEPTH = 16;
    localparam int HWM   = 12;

    logic        CLK_VIDEO = 1'b0;
    logic        RESET_N = 1'b0;
    logic        A_WE = 1'b0;
    logic [28:0] A_ADDR = '0;
    logic [63:0] A_DIN = '0;
    logic [7:0]  A_BE = '0;
    logic        A_FULL;
    logic        A_OVF;
    logic        B_REQ = 1'b0;
    logic        B_WE = 1'b0;
    logic [28:0] B_ADDR = '0;
    logic [63:0] B_DIN = '0;
    logic [7:0]  B_BE = '0;
    logic        B_ACK;
    logic [63:0] B_DOUT;
    logic        DDRAM_CLK;
    logic        DDRAM_BUSY = 1'b0;
    logic [63:0] DDRAM_DOUT = '0;
    logic        DDRAM_DOUT_READY = 1'b0;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;
    logic        DDRAM_RD;

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    fb_ddram_arbiter #(.FIFO_AW(4), .HWM(HWM)) dut (
        .CLK_VIDEO(CLK_VIDEO), .RESET_N(RESET_N),
        .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DIN(A_DIN), .A_BE(A_BE),
        .A_FULL(A_FULL), .A_OVF(A_OVF),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DIN(B_DIN), .B_BE(B_BE),
        .B_ACK(B_ACK), .B_DOUT(B_DOUT),
        .DDRAM_CLK(DDRAM_CLK), .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_DOUT(DDRAM_DOUT),
        .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
        .DDRAM_WE(DDRAM_WE), .DDRAM_RD(DDRAM_RD)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending pixel writes as a queue, the port as one outstanding command
    typedef struct packed {
        logic [28:0] a;
        logic [63:0] d;
        logic [7:0]  be;
    } cmd_t;

    cmd_t        q[$];
    cmd_t        m_c;
    int          m_phase = 0;
    int          m_sz;
    bit          m_wr = 1'b0;
    bit          m_isb = 1'b0;
    bit          m_last_a = 1'b0;
    bit          m_ack = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_bc;
    bit          m_ga;
    bit          m_nack;
    logic [28:0] m_addr = '0;
    logic [63:0] m_din = '0;
    logic [7:0]  m_be = '0;
    logic [63:0] m_dout = '0;

    always @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            q.delete();
            m_phase = 0; m_wr = 1'b0; m_isb = 1'b0; m_last_a = 1'b0;
            m_ack = 1'b0; m_ovf = 1'b0;
            m_addr = '0; m_din = '0; m_be = '0; m_dout = '0;
        end else begin
            m_sz   = q.size();
            m_bc   = B_REQ && !m_ack;
            m_nack = 1'b0;
            if (m_phase == 0) begin
                if (m_sz > 0 || m_bc) begin
                    m_ga = (m_sz > 0) && (!m_bc || m_sz >= HWM || !m_last_a);
                    if (m_ga) begin
                        m_c = q.pop_front();
                        m_addr = m_c.a; m_din = m_c.d; m_be = m_c.be;
                        m_wr = 1'b1; m_isb = 1'b0;
                    end else begin
                        m_addr = B_ADDR; m_din = B_DIN; m_be = B_BE;
                        m_wr = B_WE; m_isb = 1'b1;
                    end
                    m_last_a = m_ga;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (!DDRAM_BUSY) begin
                    if (!m_wr) m_phase = 2;
                    else begin m_phase = 0; m_nack = m_isb; end
                end
            end else begin
                if (DDRAM_DOUT_READY) begin
                    m_dout = DDRAM_DOUT; m_nack = 1'b1; m_phase = 0;
                end
            end
            if (A_WE) begin
                if (m_sz == DEPTH) m_ovf = 1'b1;
                else q.push_back('{a: A_ADDR, d: A_DIN, be: A_BE});
            end
            m_ack = m_nack;
        end
    end

    always @(negedge CLK_VIDEO) begin
        if (chk_en) begin
            chk("ddram_we",   64'(DDRAM_WE),       64'(m_phase == 1 && m_wr));
            chk("ddram_rd",   64'(DDRAM_RD),       64'(m_phase == 1 && !m_wr));
            chk("ddram_addr", 64'(DDRAM_ADDR),     64'(m_addr));
            chk("ddram_din",  DDRAM_DIN,           m_din);
            chk("ddram_be",   64'(DDRAM_BE),       64'(m_be));
            chk("b_ack",      64'(B_ACK),          64'(m_ack));
            chk("b_dout",     B_DOUT,              m_dout);
            chk("a_full",     64'(A_FULL),         64'(q.size() == DEPTH));
            chk("a_ovf",      64'(A_OVF),          64'(m_ovf));
            chk("burstcnt",   64'(DDRAM_BURSTCNT), 64'd1);
        end
    end

    // Memory responder and registered requester, advanced once per cycle
    int          rd_cd = 0;
    int          rd_lat = 3;
    logic [63:0] rd_data = 64'h0;
    bit          rd_rand = 1'b0;
    bit          spur_en = 1'b0;
    bit          b_ack_seen = 1'b0;

    task automatic tick();
        if (RESET_N === 1'b1 && DDRAM_RD === 1'b1 && DDRAM_BUSY === 1'b0) begin
            if (rd_rand) begin
                rd_lat  = $urandom_range(1, 4);
                rd_data = {$urandom, $urandom};
            end
            rd_cd = rd_lat;
        end
        @(negedge CLK_VIDEO);
        DDRAM_DOUT_READY = 1'b0;
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
                DDRAM_DOUT_READY = 1'b1;
                DDRAM_DOUT = rd_data;
            end
        end else if (spur_en && DDRAM_RD === 1'b0 && $urandom_range(0, 15) == 0) begin
            DDRAM_DOUT_READY = 1'b1;
            DDRAM_DOUT = {$urandom, $urandom};
        end
        if (b_ack_seen) B_REQ = 1'b0;
        b_ack_seen = B_ACK;
    endtask

    int n_a;
    bit seen_b;
    int a_pct;
    int busy_pct;

    initial begin
        repeat (3) tick();
        chk_en = 1'b1;
        RESET_N = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_we",    64'(DDRAM_WE),   64'd0);
            chk("rst_rd",    64'(DDRAM_RD),   64'd0);
            chk("rst_ack",   64'(B_ACK),      64'd0);
            chk("rst_full",  64'(A_FULL),     64'd0);
            chk("rst_ovf",   64'(A_OVF),      64'd0);
            chk("rst_addr",  64'(DDRAM_ADDR), 64'd0);
            chk("rst_dout",  B_DOUT,          64'd0);
        end

        // single pixel write, unstalled
        A_WE = 1'b1; A_ADDR = 29'h0000100; A_DIN = 64'h00112233_00445566; A_BE = 8'h0F;
        tick(); A_WE = 1'b0;
        chk("a1_early", 64'(DDRAM_WE), 64'd0);
        tick();
        chk("a1_we",   64'(DDRAM_WE),   64'd1);
        chk("a1_addr", 64'(DDRAM_ADDR), 64'h100);
        chk("a1_din",  DDRAM_DIN,       64'h00112233_00445566);
        chk("a1_be",   64'(DDRAM_BE),   64'h0F);
        tick();
        chk("a1_drop", 64'(DDRAM_WE), 64'd0);
        tick();

        // command held through five stalled cycles
        DDRAM_BUSY = 1'b1;
        A_WE = 1'b1; A_ADDR = 29'h111; A_DIN = 64'h1111; A_BE = 8'h11;
        tick(); A_ADDR = 29'h222; A_DIN = 64'h2222; A_BE = 8'h22;
        tick(); A_WE = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("busy_we",   64'(DDRAM_WE),   64'd1);
            chk("busy_addr", 64'(DDRAM_ADDR), 64'h111);
            chk("busy_din",  DDRAM_DIN,       64'h1111);
            if (i == 5) DDRAM_BUSY = 1'b0;
            tick();
        end
        chk("busy_drop", 64'(DDRAM_WE), 64'd0);
        tick();
        chk("busy_next_we",   64'(DDRAM_WE),   64'd1);
        chk("busy_next_addr", 64'(DDRAM_ADDR), 64'h222);
        tick(); tick();

        // FIFO overflow with the port stalled
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 16) chk("full_at16", 64'(A_FULL), 64'd0);
            if (i == 17) begin
                chk("full_at17", 64'(A_FULL), 64'd1);
                chk("ovf_at17",  64'(A_OVF),  64'd0);
            end
            if (i == 18) chk("ovf_at18", 64'(A_OVF), 64'd1);
            A_WE = 1'b1; A_ADDR = 29'(32'h200 + i);
            A_DIN = {32'hA5A5_0000 + 32'(i), 32'(i)}; A_BE = 8'(i);
            tick();
        end
        A_WE = 1'b0; DDRAM_BUSY = 1'b0;
        n_a = 0;
        for (int i = 0; i < 50; i++) begin
            if (DDRAM_WE) begin
                chk("ovf_order", 64'(DDRAM_ADDR), 64'(32'h200 + n_a));
                n_a++;
            end
            tick();
        end
        chk("ovf_count", 64'(n_a), 64'd17);
        chk("ovf_sticky", 64'(A_OVF), 64'd1);

        // reset clears the sticky flag and last_grant
        RESET_N = 1'b0; tick(); RESET_N = 1'b1; tick();
        chk("ovf_cleared", 64'(A_OVF), 64'd0);

        // contention below the high-water mark alternates A, B, A
        A_WE = 1'b1; A_ADDR = 29'h300; A_DIN = 64'h300; A_BE = 8'hFF;
        tick();
        A_ADDR = 29'h301; A_DIN = 64'h301;
        B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 29'h0B00; B_DIN = 64'hB00; B_BE = 8'hF0;
        tick(); A_WE = 1'b0;
        chk("alt_1_we",   64'(DDRAM_WE),   64'd1);
        chk("alt_1_addr", 64'(DDRAM_ADDR), 64'h300);
        tick(); tick();
        chk("alt_2_we",   64'(DDRAM_WE),   64'd1);
        chk("alt_2_addr", 64'(DDRAM_ADDR), 64'h0B00);
        tick();
        chk("alt_b_ack", 64'(B_ACK), 64'd1);
        tick();
        chk("alt_3_we",   64'(DDRAM_WE),   64'd1);
        chk("alt_3_addr", 64'(DDRAM_ADDR), 64'h301);
        tick(); tick();

        // above the high-water mark A keeps winning
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 14; i++) begin
            A_WE = 1'b1; A_ADDR = 29'(32'h400 + i); A_DIN = 64'(i); A_BE = 8'h0F;
            if (i == 3) begin
                B_REQ = 1'b1; B_WE = 1'b1; B_ADDR = 29'h0C00; B_DIN = 64'hC00; B_BE = 8'h0F;
            end
            tick();
        end
        A_WE = 1'b0; DDRAM_BUSY = 1'b0;
        n_a = 0; seen_b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (DDRAM_WE && !seen_b) begin
                if (DDRAM_ADDR == 29'h0C00) seen_b = 1'b1;
                else n_a++;
            end
            tick();
        end
        chk("hwm_a_before_b", 64'(n_a), 64'd3);
        chk("hwm_b_seen", 64'(seen_b), 64'd1);
        repeat (10) tick();

        // B read with delayed return; the pending A write waits for it
        rd_lat = 3; rd_data = 64'hDEADBEEF_CAFEF00D;
        B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 29'h0ABCDEF; B_DIN = '0; B_BE = 8'hFF;
        tick();
        chk("rd_issue", 64'(DDRAM_RD),   64'd1);
        chk("rd_addr",  64'(DDRAM_ADDR), 64'h0ABCDEF);
        A_WE = 1'b1; A_ADDR = 29'h500; A_DIN = 64'h5; A_BE = 8'h03;
        tick(); A_WE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rdwait_we",  64'(DDRAM_WE), 64'd0);
            chk("rdwait_ack", 64'(B_ACK),    64'd0);
            tick();
        end
        chk("rd_ack",  64'(B_ACK), 64'd1);
        chk("rd_dout", B_DOUT,     64'hDEADBEEF_CAFEF00D);
        tick();
        chk("rd_ack_pulse", 64'(B_ACK),      64'd0);
        chk("rd_dout_hold", B_DOUT,          64'hDEADBEEF_CAFEF00D);
        chk("rd_then_a_we", 64'(DDRAM_WE),   64'd1);
        chk("rd_then_a",    64'(DDRAM_ADDR), 64'h500);
        repeat (4) tick();

        // randomized traffic with occasional mid-operation reset
        rd_rand = 1'b1; spur_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (((cyc / 500) % 2) == 0) begin a_pct = 40; busy_pct = 30; end
            else begin a_pct = 90; busy_pct = 70; end
            A_WE   = ($urandom_range(0, 99) < a_pct);
            A_ADDR = 29'($urandom);
            A_DIN  = {$urandom, $urandom};
            A_BE   = 8'($urandom);
            DDRAM_BUSY = ($urandom_range(0, 99) < busy_pct);
            if (!B_REQ && $urandom_range(0, 99) < 20) begin
                B_REQ  = 1'b1;
                B_WE   = 1'($urandom_range(0, 1));
                B_ADDR = 29'($urandom);
                B_DIN  = {$urandom, $urandom};
                B_BE   = 8'($urandom);
            end
            RESET_N = ($urandom_range(0, 499) != 0);
            if (!RESET_N) B_REQ = 1'b0;
            tick();
        end
        RESET_N = 1'b1;
        A_WE = 1'b0; DDRAM_BUSY = 1'b0;
        repeat (5) tick();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
